// File: rtl/spm_seq.sv
// spm_seq: serial-parallel carry-save multiplier with start/done handshake and parallel result
module spm_seq #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     x,
  input  logic [WIDTH-1:0]     y,
  output logic                 busy,
  output logic                 p_valid,
  output logic                 p_bit,
  output logic                 done,
  output logic [2*WIDTH-1:0]   p
);
  localparam int CW = $clog2(2*WIDTH) + 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [WIDTH:0] x_r, s_in, a, s_n, c, c_n;
  logic [WIDTH:1] s;
  logic [2*WIDTH-1:0] y_sr;
  logic [CW-1:0] cnt;
  logic z;
  // array cells: partial product (MSB cell serially negated via z), plus left neighbour's sum and own carry
  always_comb begin
    a = (x_r & {(WIDTH+1){y_sr[0]}}) ^ {z, {WIDTH{1'b0}}};
    s_in = {1'b0, s};
    s_n = a ^ s_in ^ c;
    c_n = (a & s_in) | (a & c) | (s_in & c);
  end
  // sequencer and all datapath registers
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      p_valid <= 1'b0;
      p_bit <= 1'b0;
      p <= '0;
      x_r <= '0;
      y_sr <= '0;
      s <= '0;
      c <= '0;
      z <= 1'b0;
      cnt <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state <= RUN;
          busy <= 1'b1;
          x_r <= {signed_mode & x[WIDTH-1], x};
          y_sr <= {{WIDTH{signed_mode & y[WIDTH-1]}}, y};
          s <= '0;
          c <= '0;
          z <= 1'b0;
          cnt <= '0;
          p <= '0;
        end
        RUN: begin
          y_sr <= y_sr >> 1;
          s <= s_n[WIDTH:1];
          c <= c_n;
          z <= z | (x_r[WIDTH] & y_sr[0]);
          p_bit <= s_n[0];
          p_valid <= 1'b1;
          p <= {s_n[0], p[2*WIDTH-1:1]};
          cnt <= cnt + 1'b1;
          if (cnt == CW'(2*WIDTH-1)) begin
            state <= DONE;
            busy <= 1'b0;
            done <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          done <= 1'b0;
          p_valid <= 1'b0;
        end
      endcase
    end
endmodule

// File: tb/tb_spm_seq.sv
// tb_spm_seq: random and directed checks of spm_seq against a timing/product model
module tb_spm_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic start_i[2] = '{1'b0, 1'b0};
  logic sm_i[2] = '{1'b0, 1'b0};
  logic [31:0] x_i[2] = '{32'd0, 32'd0};
  logic [31:0] y_i[2] = '{32'd0, 32'd0};
  logic busy_o[2], pv_o[2], pb_o[2], done_o[2];
  logic [63:0] p_o[2];
  logic [15:0] p8;
  logic [31:0] p16;
  int errors = 0;
  int checks = 0;
  spm_seq #(.WIDTH(8)) u8 (.clk(clk), .rst(rst), .start(start_i[0]), .signed_mode(sm_i[0]),
    .x(x_i[0][7:0]), .y(y_i[0][7:0]), .busy(busy_o[0]), .p_valid(pv_o[0]), .p_bit(pb_o[0]),
    .done(done_o[0]), .p(p8));
  spm_seq #(.WIDTH(16)) u16 (.clk(clk), .rst(rst), .start(start_i[1]), .signed_mode(sm_i[1]),
    .x(x_i[1][15:0]), .y(y_i[1][15:0]), .busy(busy_o[1]), .p_valid(pv_o[1]), .p_bit(pb_o[1]),
    .done(done_o[1]), .p(p16));
  assign p_o[0] = {48'd0, p8};
  assign p_o[1] = {32'd0, p16};
  function automatic int wd(int n);
    return n == 0 ? 8 : 16;
  endfunction
  function automatic logic [63:0] ref_prod(int w, logic sm, logic [31:0] xa, logic [31:0] ya);
    longint m = (longint'(1) << w) - 1;
    longint xs = longint'(xa) & m;
    longint ys = longint'(ya) & m;
    if (sm && xs[w-1]) xs = xs - (longint'(1) << w);
    if (sm && ys[w-1]) ys = ys - (longint'(1) << w);
    return 64'(xs * ys) & ((64'd1 << (2*w)) - 1);
  endfunction
  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  // model: an accepted start at edge k defines every output as a function of edges since k
  logic mact[2] = '{1'b0, 1'b0};
  int age[2] = '{0, 0};
  logic mbit[2] = '{1'b0, 1'b0};
  logic [63:0] mprod[2] = '{64'd0, 64'd0};
  always @(posedge clk or posedge rst)
    for (int n = 0; n < 2; n++)
      if (rst) begin
        mact[n] <= 1'b0;
        age[n] <= 0;
        mbit[n] <= 1'b0;
        mprod[n] <= '0;
      end else if (start_i[n] && (!mact[n] || age[n] >= 2*wd(n)+1)) begin
        mact[n] <= 1'b1;
        age[n] <= 0;
        mprod[n] <= ref_prod(wd(n), sm_i[n], x_i[n], y_i[n]);
      end else if (mact[n]) begin
        if (age[n] < 1000) age[n] <= age[n] + 1;
        if (age[n] < 2*wd(n)) mbit[n] <= mprod[n][age[n]];
      end
  // compare every cycle on the falling edge
  always @(negedge clk)
    for (int n = 0; n < 2; n++) begin
      int w, ag;
      logic [63:0] ep;
      w = wd(n);
      ag = age[n];
      ep = !mact[n] ? 64'd0 : ag <= 2*w ? (mprod[n] & ((64'd1 << ag) - 1)) << (2*w - ag) : mprod[n];
      check(n ? "busy16" : "busy8", busy_o[n], mact[n] && ag <= 2*w-1);
      check(n ? "pvalid16" : "pvalid8", pv_o[n], mact[n] && ag >= 1 && ag <= 2*w);
      check(n ? "done16" : "done8", done_o[n], mact[n] && ag == 2*w);
      check(n ? "pbit16" : "pbit8", pb_o[n], mbit[n]);
      check(n ? "p16" : "p8", p_o[n], ep);
      check(n ? "busy_done16" : "busy_done8", busy_o[n] && done_o[n], 0);
    end
  task automatic op(int n, logic sm, logic [31:0] xa, logic [31:0] ya, logic [63:0] exp, string name);
    int w = wd(n);
    logic [63:0] stream = '0;
    int nb = 0;
    bit seen = 0;
    @(negedge clk);
    start_i[n] = 1'b1; sm_i[n] = sm; x_i[n] = xa; y_i[n] = ya;
    @(negedge clk);
    start_i[n] = 1'b0; sm_i[n] = ~sm; x_i[n] = $urandom; y_i[n] = $urandom;
    for (int i = 1; i <= 4*w; i++) begin
      if (pv_o[n] && nb < 64) begin
        stream[nb] = pb_o[n];
        nb++;
      end
      if (done_o[n]) begin
        check({name, "_lat"}, 64'(i), 64'(2*w+1));
        check({name, "_p"}, p_o[n], exp);
        check({name, "_stream"}, stream, exp);
        check({name, "_nbits"}, 64'(nb), 64'(2*w));
        seen = 1;
        break;
      end
      @(negedge clk);
    end
    if (!seen) check({name, "_timeout"}, done_o[n], 1);
    @(negedge clk);
  endtask
  logic [31:0] bx[3] = '{32'd200, 32'hF0, 32'd17};
  logic [31:0] by[3] = '{32'd100, 32'd5, 32'd15};
  logic bs[3] = '{1'b0, 1'b1, 1'b0};
  logic [63:0] bp[3] = '{64'h4E20, 64'hFFB0, 64'hFF};
  initial begin
    int k;
    bit saw_done;
    repeat (3) @(negedge clk);
    for (int n = 0; n < 2; n++) begin
      check("rst_busy", busy_o[n], 0);
      check("rst_done", done_o[n], 0);
      check("rst_pvalid", pv_o[n], 0);
      check("rst_pbit", pb_o[n], 0);
      check("rst_p", p_o[n], 0);
    end
    rst = 1'b0;
    check("ref_u255", ref_prod(8, 1'b0, 32'd255, 32'd255), 64'hFE01);
    check("ref_s80", ref_prod(8, 1'b1, 32'h80, 32'h80), 64'h4000);
    check("ref_m1", ref_prod(8, 1'b1, 32'hFF, 32'd1), 64'hFFFF);
    check("ref_127", ref_prod(8, 1'b1, 32'd127, 32'h80), 64'hC080);
    check("ref_16", ref_prod(16, 1'b1, 32'hFFFF, 32'h8000), 64'h8000);
    op(0, 1'b0, 32'd255, 32'd255, 64'hFE01, "u255");
    op(0, 1'b1, 32'h80, 32'h80, 64'h4000, "s80");
    op(0, 1'b1, 32'hFF, 32'd1, 64'hFFFF, "sm1");
    op(0, 1'b1, 32'd127, 32'h80, 64'hC080, "s127");
    @(negedge clk);
    start_i[0] = 1'b1; sm_i[0] = bs[0]; x_i[0] = bx[0]; y_i[0] = by[0];
    for (int j = 0; j < 3; j++) begin
      repeat (j == 0 ? 1 : 2) @(negedge clk);
      if (j < 2) begin
        sm_i[0] = bs[j+1]; x_i[0] = bx[j+1]; y_i[0] = by[j+1];
      end else start_i[0] = 1'b0;
      k = 1;
      while (!done_o[0] && k < 40) begin
        @(negedge clk);
        k++;
      end
      check("b2b_done", done_o[0], 1);
      check("b2b_lat", 64'(k), 64'd17);
      check("b2b_p", p_o[0], bp[j]);
    end
    @(negedge clk);
    @(negedge clk);
    start_i[0] = 1'b1; sm_i[0] = 1'b0; x_i[0] = 32'd12; y_i[0] = 32'd13;
    @(negedge clk);
    start_i[0] = 1'b0;
    repeat (4) @(negedge clk);
    start_i[0] = 1'b1; x_i[0] = 32'd255; y_i[0] = 32'd255;
    @(negedge clk);
    start_i[0] = 1'b0;
    k = 6;
    while (!done_o[0] && k < 40) begin
      @(negedge clk);
      k++;
    end
    check("ign_lat", 64'(k), 64'd17);
    check("ign_p", p_o[0], 64'd156);
    start_i[0] = 1'b1; sm_i[0] = 1'b1; x_i[0] = 32'h80; y_i[0] = 32'h7F;
    @(negedge clk);
    start_i[0] = 1'b0;
    check("ign_idle", busy_o[0], 0);
    check("ign_hold", p_o[0], 64'd156);
    @(negedge clk);
    start_i[0] = 1'b1; sm_i[0] = 1'b0; x_i[0] = 32'd100; y_i[0] = 32'd100;
    @(negedge clk);
    start_i[0] = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_busy", busy_o[0], 0);
    check("arst_done", done_o[0], 0);
    check("arst_pvalid", pv_o[0], 0);
    check("arst_pbit", pb_o[0], 0);
    check("arst_p", p_o[0], 0);
    @(negedge clk);
    rst = 1'b0;
    saw_done = 0;
    repeat (40) begin
      @(negedge clk);
      saw_done = saw_done | done_o[0];
    end
    check("arst_nodone", saw_done, 0);
    op(0, 1'b0, 32'd3, 32'd5, 64'd15, "after_rst");
    repeat (1000) begin
      logic sm;
      logic [31:0] xa, ya;
      sm = 1'($urandom_range(0, 1));
      xa = $urandom & 32'hFFFF;
      ya = $urandom & 32'hFFFF;
      op(1, sm, xa, ya, ref_prod(16, sm, xa, ya), "rand");
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
